count_run_arbiter: RTL and testbench
====================================

// Module: count_run_arbiter
// PURPOSE
//  Shares one programmable modulo counter between two requesters. Each requester asks for a
//  counting run of a given modulus and lap count. The block grants requesters round-robin,
//  sequences the counter through the requested run, and reports wrap and completion.
//  It sits between the control logic and the counter datapath that drives count displays
//  and timebases.
// PARAMETERS
//  WIDTH  4  counter / modulus width; mod 0 encodes full range 2**WIDTH
//  LAPW   4  lap-count width; laps 0 is treated as 1
// PORTS
//  clkIn    in   1      single clock; all state updates on posedge
//  rstIn    in   1      synchronous, active-high reset
//  req0In   in   1      requester 0 run request; hold high until doneOut[0]
//  mod0In   in   WIDTH  requester 0 modulus; sampled at grant
//  laps0In  in   LAPW   requester 0 number of full wraps; sampled at grant
//  req1In   in   1      requester 1 run request
//  mod1In   in   WIDTH  requester 1 modulus
//  laps1In  in   LAPW   requester 1 lap count
//  gntOut   out  2      one-hot grant; at most one bit set
//  busyOut  out  1      high in RUN or DONE
//  Dat      out  WIDTH  current count value
//  wrapOut  out  1      high in the RUN cycle where Dat == modulus-1
//  doneOut  out  2      one-cycle completion pulse, bit = owner
// BEHAVIOUR
//  Reset (rstIn=1 at posedge): state IDLE, Dat=0, gntOut=00, doneOut=00, busyOut=0,
//  lastOwner=1, so requester 0 wins the first tie. Reset overrides everything, including mid-run.
//  FSM states are IDLE, RUN, DONE; encoding lives in the package.
//  IDLE
//   - Dat=0.
//   - If exactly one request is high, that requester is granted.
//   - If both are high, the winner is ~lastOwner.
//   - At the grant edge: latch modulus and laps, set owner, gntOut=onehot(owner), state RUN,
//     Dat=0. The grant is visible the cycle after the request is sampled.
//  RUN
//   - Dat increments by 1 each cycle.
//   - When Dat == modLat-1: next Dat=0, wrapOut=1 this cycle, lapsRem decrements.
//   - mod=1: Dat stays 0 and wrapOut=1 every RUN cycle.
//   - mod=0: wraps at 2**WIDTH-1 via natural overflow.
//   - Wrap with lapsRem==1: next state DONE.
//   - Abort: if the owner's req is low in any RUN cycle, next state IDLE, Dat=0, gntOut=00,
//     no doneOut, and lastOwner is still updated to owner.
//   - Abort takes precedence over a simultaneous final wrap: no done pulse.
//  DONE (exactly 1 cycle)
//   - doneOut[owner]=1, Dat=0, gntOut held, wrapOut=0.
//   - Requests are ignored.
//   - Next state IDLE; lastOwner=owner; gntOut=00.
//  Run length: mod*laps RUN cycles (mod 0 counts as 2**WIDTH), then 1 DONE cycle,
//  then 1 IDLE cycle minimum before the next grant.
//  Non-owner requests during RUN/DONE are held pending and are not dropped.
//  Input changes to modN/lapsN after the grant have no effect on the run in progress.
//  All outputs are registered except wrapOut, which is decoded from registered state only.
// STRUCTURE
//  Package cra_pkg: state encoding (IDLE/RUN/DONE localparams) and the OWN0/OWN1 constants.
//  Sub-module mod_counter_core (clkIn, rstIn, clrIn, enIn, modIn, Dat, wrapOut):
//   - the shared counter;
//   - clear has priority over enable.
//  The arbiter and FSM live in this top module.
// TESTING
//  1 Single run: req0=1, mod0=9, laps0=1.
//    -> gnt=01 one cycle later; Dat 0..8 with wrapOut at Dat=8; doneOut=01 in cycle 10 after grant.
//  2 Tie: req0=req1=1 from reset, both mod=3 laps=2.
//    -> owner 0 runs 6 cycles + done; then owner 1 granted after one IDLE cycle; done=10.
//  3 Round-robin fairness: both held high for 4 runs.
//    -> grants alternate 01,10,01,10; neither requester is starved.
//  4 Abort: req0 drops at Dat=4 (mod 9).
//    -> next cycle IDLE, Dat=0, gnt=00, no doneOut; a pending req1 is granted next.
//  5 Edge moduli: mod=1 laps=3 -> 3 RUN cycles all with wrapOut=1;
//    mod=0 laps=1 (WIDTH=4) -> Dat 0..15, done after 16 cycles.
//  6 Reset mid-run: rstIn=1 at Dat=5.
//    -> next cycle Dat=0, gnt=00, done=00; req0 wins the next tie (lastOwner=1).

Source files
------------

// File: rtl/cra_pkg.sv
// Shared types and constants for the count_run_arbiter slice.
package cra_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam logic OWN0 = 1'b0;
  localparam logic OWN1 = 1'b1;

  function automatic logic [1:0] onehot(input logic owner);
    return owner ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/mod_counter_core.sv
// Programmable modulo counter; modulus 0 counts the full 2**WIDTH range.
module mod_counter_core #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clkIn,
  input  logic             rstIn,
  input  logic             clrIn,
  input  logic             enIn,
  input  logic [WIDTH-1:0] modIn,
  output logic [WIDTH-1:0] Dat,
  output logic             wrapOut
);

  localparam logic [WIDTH-1:0] One = 1;

  logic [WIDTH-1:0] last_val;
  logic             at_last;

  // mod 0 underflows to all ones, giving the full-range wrap for free
  assign last_val = modIn - One;
  assign at_last  = (Dat == last_val);
  assign wrapOut  = enIn && at_last;

  always_ff @(posedge clkIn) begin
    if (rstIn || clrIn) begin
      Dat <= '0;
    end else if (enIn) begin
      Dat <= at_last ? '0 : Dat + One;
    end
  end

endmodule

// File: rtl/count_run_arbiter.sv
// Round-robin arbiter sharing one modulo counter between two requesters for lapped runs.
module count_run_arbiter
  import cra_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned LAPW  = 4
) (
  input  logic             clkIn,
  input  logic             rstIn,
  input  logic             req0In,
  input  logic [WIDTH-1:0] mod0In,
  input  logic [LAPW-1:0]  laps0In,
  input  logic             req1In,
  input  logic [WIDTH-1:0] mod1In,
  input  logic [LAPW-1:0]  laps1In,
  output logic [1:0]       gntOut,
  output logic             busyOut,
  output logic [WIDTH-1:0] Dat,
  output logic             wrapOut,
  output logic [1:0]       doneOut
);

  localparam logic [LAPW-1:0] LapOne = 1;

  state_e           state_q, state_d;
  logic             owner_q, owner_d;
  logic             last_owner_q, last_owner_d;
  logic [WIDTH-1:0] mod_q, mod_d;
  logic [LAPW-1:0]  laps_q, laps_d;
  logic [1:0]       gnt_q, gnt_d;
  logic [1:0]       done_q, done_d;
  logic             busy_q, busy_d;

  logic             winner;
  logic [LAPW-1:0]  win_laps;
  logic             own_req;
  logic             cnt_clr;
  logic             cnt_en;
  logic             cnt_wrap;

  assign winner   = (req0In && req1In) ? ~last_owner_q : req1In;
  assign win_laps = winner ? laps1In : laps0In;
  assign own_req  = owner_q ? req1In : req0In;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    mod_d        = mod_q;
    laps_d       = laps_q;
    gnt_d        = gnt_q;
    done_d       = 2'b00;
    busy_d       = busy_q;
    cnt_clr      = 1'b1;
    cnt_en       = 1'b0;
    unique case (state_q)
      StIdle: begin
        gnt_d  = 2'b00;
        busy_d = 1'b0;
        if (req0In || req1In) begin
          owner_d = winner;
          mod_d   = winner ? mod1In : mod0In;
          laps_d  = (win_laps == '0) ? LapOne : win_laps;
          gnt_d   = onehot(winner);
          busy_d  = 1'b1;
          state_d = StRun;
        end
      end
      StRun: begin
        cnt_en  = 1'b1;
        cnt_clr = 1'b0;
        // Abort wins over a coincident final wrap, so no done pulse is raised
        if (!own_req) begin
          cnt_clr      = 1'b1;
          gnt_d        = 2'b00;
          busy_d       = 1'b0;
          last_owner_d = owner_q;
          state_d      = StIdle;
        end else if (cnt_wrap) begin
          laps_d = laps_q - LapOne;
          if (laps_q == LapOne) begin
            done_d  = onehot(owner_q);
            state_d = StDone;
          end
        end
      end
      StDone: begin
        gnt_d        = 2'b00;
        busy_d       = 1'b0;
        last_owner_d = owner_q;
        state_d      = StIdle;
      end
      default: begin
        gnt_d   = 2'b00;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clkIn) begin
    if (rstIn) begin
      state_q      <= StIdle;
      owner_q      <= OWN0;
      last_owner_q <= OWN1;
      mod_q        <= '0;
      laps_q       <= '0;
      gnt_q        <= 2'b00;
      done_q       <= 2'b00;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      mod_q        <= mod_d;
      laps_q       <= laps_d;
      gnt_q        <= gnt_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
    end
  end

  mod_counter_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clkIn   (clkIn),
    .rstIn   (rstIn),
    .clrIn   (cnt_clr),
    .enIn    (cnt_en),
    .modIn   (mod_q),
    .Dat     (Dat),
    .wrapOut (cnt_wrap)
  );

  assign gntOut  = gnt_q;
  assign busyOut = busy_q;
  assign doneOut = done_q;
  assign wrapOut = cnt_wrap;

endmodule

// File: tb/tb_count_run_arbiter.sv
// Directed bench for count_run_arbiter with hand-computed expectations.
module tb_count_run_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1;
  logic [3:0] mod0, mod1;
  logic [3:0] laps0, laps1;
  logic [1:0] gnt;
  logic       busy;
  logic [3:0] dat;
  logic       wrap;
  logic [1:0] done;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  count_run_arbiter #(
    .WIDTH (4),
    .LAPW  (4)
  ) dut (
    .clkIn   (clk),
    .rstIn   (rst),
    .req0In  (req0),
    .mod0In  (mod0),
    .laps0In (laps0),
    .req1In  (req1),
    .mod1In  (mod1),
    .laps1In (laps1),
    .gntOut  (gnt),
    .busyOut (busy),
    .Dat     (dat),
    .wrapOut (wrap),
    .doneOut (done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    mod0 = 4'd0; mod1 = 4'd0; laps0 = 4'd0; laps1 = 4'd0;
    tick();
    tick();
    chk("rst_dat", dat, 0);
    chk("rst_gnt", gnt, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wrap", wrap, 0);

    // 1: single run, mod 9 laps 1
    rst = 1'b0; req0 = 1'b1; mod0 = 4'd9; laps0 = 4'd1;
    tick();
    chk("t1_gnt", gnt, 2'b01);
    chk("t1_busy", busy, 1);
    for (int i = 0; i < 9; i++) begin
      chk("t1_dat", dat, i);
      chk("t1_wrap", wrap, (i == 8));
      chk("t1_nodone", done, 0);
      tick();
    end
    chk("t1_done", done, 2'b01);
    chk("t1_done_gnt", gnt, 2'b01);
    chk("t1_done_dat", dat, 0);
    chk("t1_done_wrap", wrap, 0);
    chk("t1_done_busy", busy, 1);
    req0 = 1'b0;
    tick();
    chk("t1_idle_gnt", gnt, 0);
    chk("t1_idle_done", done, 0);
    chk("t1_idle_busy", busy, 0);

    // 2: tie from reset, both mod 3 laps 2
    rst = 1'b1;
    tick();
    rst = 1'b0; req0 = 1'b1; req1 = 1'b1;
    mod0 = 4'd3; laps0 = 4'd2; mod1 = 4'd3; laps1 = 4'd2;
    tick();
    chk("t2_gnt0", gnt, 2'b01);
    for (int i = 0; i < 6; i++) begin
      chk("t2_dat0", dat, i % 3);
      chk("t2_wrap0", wrap, ((i % 3) == 2));
      tick();
    end
    chk("t2_done0", done, 2'b01);
    req0 = 1'b0;
    tick();
    chk("t2_idle_gnt", gnt, 0);
    tick();
    chk("t2_gnt1", gnt, 2'b10);
    for (int i = 0; i < 6; i++) begin
      chk("t2_dat1", dat, i % 3);
      tick();
    end
    chk("t2_done1", done, 2'b10);
    req1 = 1'b0;
    tick();

    // 3: fairness over 4 runs, both held high, mod 2 laps 1
    req0 = 1'b1; req1 = 1'b1;
    mod0 = 4'd2; laps0 = 4'd1; mod1 = 4'd2; laps1 = 4'd1;
    tick();
    for (int r = 0; r < 4; r++) begin
      chk("t3_gnt", gnt, (r % 2 == 0) ? 2'b01 : 2'b10);
      tick();
      tick();
      chk("t3_done", done, (r % 2 == 0) ? 2'b01 : 2'b10);
      tick();
      chk("t3_idle", gnt, 0);
      if (r < 3) tick();
    end
    req0 = 1'b0; req1 = 1'b0;
    tick();

    // 4: abort at Dat=4 with req1 pending; mod0 change after grant is ignored
    req0 = 1'b1; mod0 = 4'd9; laps0 = 4'd1;
    req1 = 1'b1; mod1 = 4'd2; laps1 = 4'd1;
    tick();
    chk("t4_gnt0", gnt, 2'b01);
    mod0 = 4'd3;
    for (int i = 0; i < 4; i++) tick();
    chk("t4_dat4", dat, 4);
    chk("t4_nowrap", wrap, 0);
    req0 = 1'b0;
    tick();
    chk("t4_ab_dat", dat, 0);
    chk("t4_ab_gnt", gnt, 0);
    chk("t4_ab_done", done, 0);
    chk("t4_ab_busy", busy, 0);
    tick();
    chk("t4_gnt1", gnt, 2'b10);
    tick();
    chk("t4_dat1", dat, 1);
    chk("t4_wrap1", wrap, 1);
    tick();
    chk("t4_done1", done, 2'b10);
    req1 = 1'b0;
    tick();

    // 5: mod 1 laps 3, mod 0 laps 1, mod 2 laps 0
    req0 = 1'b1; mod0 = 4'd1; laps0 = 4'd3;
    tick();
    chk("t5a_gnt", gnt, 2'b01);
    for (int i = 0; i < 3; i++) begin
      chk("t5a_dat", dat, 0);
      chk("t5a_wrap", wrap, 1);
      chk("t5a_nodone", done, 0);
      tick();
    end
    chk("t5a_done", done, 2'b01);
    req0 = 1'b0;
    tick();
    req0 = 1'b1; mod0 = 4'd0; laps0 = 4'd1;
    tick();
    for (int i = 0; i < 16; i++) begin
      chk("t5b_dat", dat, i);
      chk("t5b_wrap", wrap, (i == 15));
      tick();
    end
    chk("t5b_done", done, 2'b01);
    req0 = 1'b0;
    tick();
    req0 = 1'b1; mod0 = 4'd2; laps0 = 4'd0;
    tick();
    chk("t5c_gnt", gnt, 2'b01);
    tick();
    chk("t5c_wrap", wrap, 1);
    tick();
    chk("t5c_done", done, 2'b01);
    req0 = 1'b0;
    tick();

    // 6: reset at Dat=5, then tie goes to requester 0
    req0 = 1'b1; mod0 = 4'd9; laps0 = 4'd1;
    tick();
    for (int i = 0; i < 5; i++) tick();
    chk("t6_dat5", dat, 5);
    rst = 1'b1;
    tick();
    chk("t6_rst_dat", dat, 0);
    chk("t6_rst_gnt", gnt, 0);
    chk("t6_rst_done", done, 0);
    chk("t6_rst_busy", busy, 0);
    rst = 1'b0; req0 = 1'b1; req1 = 1'b1;
    mod0 = 4'd2; laps0 = 4'd1; mod1 = 4'd2; laps1 = 4'd1;
    tick();
    chk("t6_tie_gnt", gnt, 2'b01);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
